keccak_round_sequencer: RTL and testbench
=========================================

KECCAK_ROUND_SEQUENCER -- requirements
Module: KECCAK_ROUND_SEQUENCER

Interface
REQ-001 Parameter NUM_ROUNDS SHALL default to 24 and set the number of Keccak-f rounds per permutation (legal range 2..32).
REQ-002 Parameter PERM_CNT_WIDTH SHALL default to 16 and set the width of the completed-permutation counter.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-004 A_RST_N  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 CE  input  1  SHALL be the clock enable; CE=0 freezes all sequencing state.
REQ-006 ABORT  input  1  SHALL be a synchronous abort of the current permutation.
REQ-007 START  input  1  SHALL be the valid signal requesting a new permutation on the absorbed state.
REQ-008 START_READY  output  1  SHALL indicate that START is accepted this cycle.
REQ-009 COUNTER  output  5  SHALL carry the round index for the combinational round-constant table.
REQ-010 ROUND_EN  output  1  SHALL be the state-register update enable for the round datapath.
REQ-011 FIRST_ROUND  output  1  SHALL select the absorbed input into the state mux.
REQ-012 LAST_ROUND  output  1  SHALL flag the final round of a permutation.
REQ-013 DIGEST_VALID  output  1  SHALL indicate that the permuted state is stable and available.
REQ-014 DIGEST_READY  input  1  SHALL be the consumer acceptance of the permuted state.
REQ-015 BUSY  output  1  SHALL be high in any state other than IDLE.
REQ-016 PERM_COUNT  output  PERM_CNT_WIDTH  SHALL count completed permutations.

Function
REQ-017 FSM SHALL have states IDLE, RUN and HOLD.
REQ-018 START_READY SHALL be CE AND ((state==IDLE) OR (state==HOLD AND DIGEST_READY)) AND NOT ABORT.
REQ-019 Accept (START AND START_READY) SHALL move the FSM to RUN with COUNTER=0 on the next edge.
REQ-020 In RUN, ROUND_EN SHALL equal CE; ROUND_EN SHALL be 0 in IDLE and HOLD.
REQ-021 In RUN with CE=1, COUNTER SHALL increment by 1 per edge; COUNTER==NUM_ROUNDS-1 SHALL instead move the FSM to HOLD with COUNTER held at NUM_ROUNDS-1.
REQ-022 A permutation SHALL take exactly NUM_ROUNDS CE-qualified cycles in RUN; DIGEST_VALID SHALL rise on the edge after the last round.
REQ-023 FIRST_ROUND SHALL be 1 exactly when state==RUN and COUNTER==0; LAST_ROUND SHALL be 1 exactly when state==RUN and COUNTER==NUM_ROUNDS-1.
REQ-024 DIGEST_VALID SHALL be 1 exactly in HOLD and SHALL stay high until DIGEST_READY=1 with CE=1.
REQ-025 In HOLD, DIGEST_READY=1 with CE=1 and no START SHALL move the FSM to IDLE with COUNTER=0.
REQ-026 In HOLD, DIGEST_READY=1 together with START, CE=1 and no ABORT SHALL move the FSM directly to RUN with COUNTER=0, with no IDLE bubble.
REQ-027 PERM_COUNT SHALL increment by 1 on every DIGEST_VALID AND DIGEST_READY AND CE cycle and SHALL wrap from all-ones to 0.
REQ-028 CE=0 SHALL hold state, COUNTER and PERM_COUNT; no handshake completes and START_READY=0.
REQ-029 ABORT=1 SHALL take priority over every other input regardless of CE, forcing IDLE and COUNTER=0 on the next edge; PERM_COUNT SHALL be unchanged and an in-flight digest SHALL be discarded.
REQ-030 START in RUN SHALL be ignored, since START_READY=0 there.
REQ-031 COUNTER SHALL never exceed NUM_ROUNDS-1.

Reset
REQ-032 While A_RST_N=0, the FSM SHALL be IDLE with COUNTER=0 and PERM_COUNT=0.
REQ-033 While A_RST_N=0, START_READY, ROUND_EN, FIRST_ROUND, LAST_ROUND, DIGEST_VALID and BUSY SHALL all be 0.
REQ-034 Reset asserted mid-RUN or mid-HOLD SHALL abandon the permutation immediately, with no DIGEST_VALID pulse.
REQ-035 After A_RST_N deasserts, the first START SHALL be accepted on the first edge with CE=1.

Verification
REQ-036 Single permutation with CE=1: START pulse -> COUNTER 0..23 with ROUND_EN=1 for 24 cycles, FIRST_ROUND at 0, LAST_ROUND at 23, DIGEST_VALID on cycle 25, DIGEST_READY -> IDLE and PERM_COUNT=1.
REQ-037 CE stall: CE=0 for 3 cycles at COUNTER=10 -> COUNTER stays 10 and ROUND_EN=0, then resumes; DIGEST_VALID arrives 3 cycles later than in the unstalled case.
REQ-038 Back-to-back: START and DIGEST_READY both high in HOLD -> next cycle RUN with COUNTER=0 and FIRST_ROUND=1, and PERM_COUNT increments.
REQ-039 Backpressure: DIGEST_READY=0 for 5 cycles -> DIGEST_VALID held, COUNTER=23, START_READY=0, ROUND_EN=0.
REQ-040 ABORT at COUNTER=7 with CE=0 -> IDLE and COUNTER=0 next edge, PERM_COUNT unchanged, and no DIGEST_VALID.
REQ-041 A_RST_N low at COUNTER=15 -> all outputs 0 asynchronously; with PERM_CNT_WIDTH=2, 4 completed permutations -> PERM_COUNT wraps 3->0.

Source files
------------

// File: rtl/keccak_round_sequencer.sv
// Round sequencer for an iterative Keccak-f permutation core: steps the round
// index, gates the state register, and hands the permuted state to a consumer.
module keccak_round_sequencer #(
   parameter int unsigned NUM_ROUNDS     = 24,
   parameter int unsigned PERM_CNT_WIDTH = 16
) (
   input  logic                      CLK,
   input  logic                      A_RST_N,
   input  logic                      CE,
   input  logic                      ABORT,
   input  logic                      START,
   output logic                      START_READY,
   output logic [4:0]                COUNTER,
   output logic                      ROUND_EN,
   output logic                      FIRST_ROUND,
   output logic                      LAST_ROUND,
   output logic                      DIGEST_VALID,
   input  logic                      DIGEST_READY,
   output logic                      BUSY,
   output logic [PERM_CNT_WIDTH-1:0] PERM_COUNT
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_e;

   localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - 1);

   state_e                    state_q, state_d;
   logic [4:0]                counter_q, counter_d;
   logic [PERM_CNT_WIDTH-1:0] perm_count_q, perm_count_d;
   logic                      run_q, run_d;
   logic                      first_q, first_d;
   logic                      last_q, last_d;
   logic                      valid_q, valid_d;
   logic                      busy_q, busy_d;
   logic                      start_ready;
   logic                      accept;

   // Gated by reset so the handshake stays closed while the block is held in reset.
   assign start_ready = A_RST_N & CE & ~ABORT &
                        ((state_q == IDLE) | ((state_q == HOLD) & DIGEST_READY));
   assign accept      = START & start_ready;

   always_comb begin
      state_d      = state_q;
      counter_d    = counter_q;
      perm_count_d = perm_count_q;

      if (ABORT) begin
         state_d   = IDLE;
         counter_d = '0;
      end else if (CE) begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d   = RUN;
                  counter_d = '0;
               end
            end
            RUN: begin
               if (counter_q == LAST_IDX) begin
                  state_d = HOLD;
               end else begin
                  counter_d = counter_q + 5'd1;
               end
            end
            HOLD: begin
               if (DIGEST_READY) begin
                  perm_count_d = perm_count_q + PERM_CNT_WIDTH'(1);
                  counter_d    = '0;
                  state_d      = accept ? RUN : IDLE;
               end
            end
            default: begin
               state_d   = IDLE;
               counter_d = '0;
            end
         endcase
      end

      run_d   = (state_d == RUN);
      first_d = (state_d == RUN) && (counter_d == '0);
      last_d  = (state_d == RUN) && (counter_d == LAST_IDX);
      valid_d = (state_d == HOLD);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge A_RST_N) begin
      if (!A_RST_N) begin
         state_q      <= IDLE;
         counter_q    <= '0;
         perm_count_q <= '0;
         run_q        <= 1'b0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         counter_q    <= counter_d;
         perm_count_q <= perm_count_d;
         run_q        <= run_d;
         first_q      <= first_d;
         last_q       <= last_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
      end
   end

   assign START_READY  = start_ready;
   assign COUNTER      = counter_q;
   assign ROUND_EN     = run_q & CE;
   assign FIRST_ROUND  = first_q;
   assign LAST_ROUND   = last_q;
   assign DIGEST_VALID = valid_q;
   assign BUSY         = busy_q;
   assign PERM_COUNT   = perm_count_q;

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Randomized + directed bench for keccak_round_sequencer against a position-based
// reference model (-1 idle, 0..N-1 running round, N holding the digest).
module tb_keccak_round_sequencer;

   localparam int N = 24;

   logic        CLK = 1'b0;
   logic        A_RST_N = 1'b0;
   logic        CE = 1'b0;
   logic        ABORT = 1'b0;
   logic        START = 1'b0;
   logic        DIGEST_READY = 1'b0;

   logic        sr_a, re_a, fr_a, lr_a, dv_a, busy_a;
   logic [4:0]  ctr_a;
   logic [15:0] pc_a;
   logic        sr_b, re_b, fr_b, lr_b, dv_b, busy_b;
   logic [4:0]  ctr_b;
   logic [1:0]  pc_b;

   int checks = 0;
   int errors = 0;
   int pos    = -1;
   int perms  = 0;

   always #5 CLK = ~CLK;

   keccak_round_sequencer dut (
      .CLK(CLK), .A_RST_N(A_RST_N), .CE(CE), .ABORT(ABORT), .START(START),
      .START_READY(sr_a), .COUNTER(ctr_a), .ROUND_EN(re_a), .FIRST_ROUND(fr_a),
      .LAST_ROUND(lr_a), .DIGEST_VALID(dv_a), .DIGEST_READY(DIGEST_READY),
      .BUSY(busy_a), .PERM_COUNT(pc_a)
   );

   keccak_round_sequencer #(.NUM_ROUNDS(N), .PERM_CNT_WIDTH(2)) dut_w (
      .CLK(CLK), .A_RST_N(A_RST_N), .CE(CE), .ABORT(ABORT), .START(START),
      .START_READY(sr_b), .COUNTER(ctr_b), .ROUND_EN(re_b), .FIRST_ROUND(fr_b),
      .LAST_ROUND(lr_b), .DIGEST_VALID(dv_b), .DIGEST_READY(DIGEST_READY),
      .BUSY(busy_b), .PERM_COUNT(pc_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t pos=%0d)", tag, got, exp, $time, pos);
      end
   endtask

   task automatic check_outputs();
      logic       idle, run, hold, e_sr;
      logic [4:0] e_ctr;
      logic [31:0] p32;
      idle  = (pos < 0);
      run   = (pos >= 0) && (pos < N);
      hold  = (pos == N);
      e_ctr = idle ? 5'd0 : (hold ? 5'(N - 1) : 5'(pos));
      e_sr  = A_RST_N && CE && !ABORT && (idle || (hold && DIGEST_READY));
      p32   = perms;
      check("start_ready", {31'd0, sr_a},   {31'd0, e_sr});
      check("counter",     {27'd0, ctr_a},  {27'd0, e_ctr});
      check("round_en",    {31'd0, re_a},   {31'd0, run && CE});
      check("first_round", {31'd0, fr_a},   {31'd0, pos == 0});
      check("last_round",  {31'd0, lr_a},   {31'd0, pos == N - 1});
      check("digest_valid",{31'd0, dv_a},   {31'd0, hold});
      check("busy",        {31'd0, busy_a}, {31'd0, !idle});
      check("perm_count",  {16'd0, pc_a},   {16'd0, p32[15:0]});
      check("w_start_ready", {31'd0, sr_b},  {31'd0, e_sr});
      check("w_counter",     {27'd0, ctr_b}, {27'd0, e_ctr});
      check("w_digest_valid",{31'd0, dv_b},  {31'd0, hold});
      check("w_perm_count",  {30'd0, pc_b},  {30'd0, p32[1:0]});
   endtask

   task automatic step(input bit ce, input bit ab, input bit st, input bit dr);
      @(negedge CLK);
      CE = ce; ABORT = ab; START = st; DIGEST_READY = dr;
      #1;
      check_outputs();
      if (ab) begin
         pos = -1;
      end else if (ce) begin
         if (pos < 0) begin
            if (st) pos = 0;
         end else if (pos < N) begin
            pos++;
         end else if (dr) begin
            perms++;
            pos = st ? 0 : -1;
         end
      end
      @(posedge CLK);
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 4 * N && pos != target; i++) step(1, 0, 0, 0);
      check("run_to_reached", pos, target);
   endtask

   task automatic reset_now();
      @(negedge CLK);
      #2;
      A_RST_N = 1'b0; CE = 1'b1; START = 1'b1; ABORT = 1'b0; DIGEST_READY = 1'b1;
      pos = -1; perms = 0;
      #1;
      check_outputs();
      @(posedge CLK);
      #1;
      check_outputs();
      @(negedge CLK);
      A_RST_N = 1'b1; START = 1'b0;
   endtask

   initial begin
      int dv_cycles;
      #12;
      check_outputs();
      @(negedge CLK);
      A_RST_N = 1'b1;

      // single permutation, backpressure, then release
      step(1, 0, 1, 0);
      check("first_accept", pos, 0);
      dv_cycles = 0;
      while (pos != N && dv_cycles < 100) begin step(1, 0, 1, 0); dv_cycles++; end
      check("run_len", dv_cycles, N);
      for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      check("perms_one", perms, 1);

      // CE stall at round 10
      step(1, 0, 1, 0);
      run_to(10);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
      run_to(N);

      // back-to-back restart from HOLD
      step(1, 0, 1, 1);
      step(1, 0, 0, 0);

      // abort at round 7 with CE low
      run_to(7);
      step(0, 1, 1, 1);
      step(1, 0, 0, 0);

      // abort while holding a digest
      step(1, 0, 1, 0);
      run_to(N);
      step(1, 1, 0, 1);
      step(1, 0, 0, 0);

      // asynchronous reset mid-run
      step(1, 0, 1, 0);
      run_to(15);
      reset_now();

      // wrap: five chained permutations
      step(1, 0, 1, 0);
      for (int p = 0; p < 5; p++) begin
         run_to(N);
         step(1, 0, 1, 1);
      end
      run_to(N);
      step(1, 0, 0, 1);
      check("perms_wrap", perms, 6);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) reset_now();
         step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 50);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
